uart_txrx: RTL and testbench

Full-duplex 8N1 UART transceiver: one receiver and one transmitter sharing a clock, with a fixed baud divisor.
- RX deserialises the serial line into bytes and flags each byte with a one-cycle valid strobe.
- TX serialises a byte when a one-cycle start strobe arrives.
- Sits between the board serial pins and the host-side byte interface. Default setup is a 25 MHz clock at 115200 baud.

---
 rtl/uart_txrx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_txrx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent receiver and transmitter with a fixed baud divisor.
// Define UART_ECHO_EN to loop every valid received byte back into the transmitter.
module uart_txrx #(
   parameter int clks_per_bit = 217
) (
   input  logic       i_clock,
   input  logic       i_rst_n,
   input  logic       i_rx_uart,
   output logic       o_rx_dv,
   output logic [7:0] o_rx_byte,
   input  logic       i_tx_dv,
   input  logic [7:0] i_tx_byte,
   output logic       o_tx_uart,
   output logic       o_tx_active,
   output logic       o_tx_done
);
   localparam int CW = $clog2(clks_per_bit) + 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(clks_per_bit - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'((clks_per_bit - 1) / 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_e;

   state_e          rx_state_q, rx_state_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_idx_q, rx_idx_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            rx_dv_q, rx_dv_d;
   logic            rx_meta_q, rx_sync_q;

   state_e          tx_state_q, tx_state_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_idx_q, tx_idx_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_serial_q, tx_serial_d;
   logic            tx_active_q, tx_active_d;
   logic            tx_done_q, tx_done_d;

   logic            tx_start;
   logic [7:0]      tx_byte;

`ifdef UART_ECHO_EN
   assign tx_start = rx_dv_q;
   assign tx_byte  = rx_byte_q;
`else
   assign tx_start = i_tx_dv;
   assign tx_byte  = i_tx_byte;
`endif

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_dv_q    <= 1'b0;
      end else begin
         rx_meta_q  <= i_rx_uart;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_dv_q    <= rx_dv_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_dv_d    = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d = '0;
            rx_idx_d = '0;
            if (!rx_sync_q) rx_state_d = S_START;
         end
         S_START: begin
            // A start bit that is no longer low at its midpoint is a glitch.
            if (rx_cnt_q == HALF_BIT) begin
               rx_cnt_d   = '0;
               rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt_q < BIT_LAST) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else begin
               rx_cnt_d             = '0;
               rx_shift_d[rx_idx_q] = rx_sync_q;
               if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
               else                  rx_idx_d   = rx_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (rx_cnt_q < BIT_LAST) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_dv_d    = 1'b1;
                  rx_byte_d  = rx_shift_q;
                  rx_state_d = S_CLEANUP;
               end else begin
                  rx_state_d = S_IDLE;
               end
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= '0;
         tx_data_q   <= '0;
         tx_serial_q <= 1'b1;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_idx_q    <= tx_idx_d;
         tx_data_q   <= tx_data_d;
         tx_serial_q <= tx_serial_d;
         tx_active_q <= tx_active_d;
         tx_done_q   <= tx_done_d;
      end
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_idx_d    = tx_idx_q;
      tx_data_d   = tx_data_q;
      tx_active_d = tx_active_q;
      tx_done_d   = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            tx_idx_d = '0;
            if (tx_start) begin
               tx_data_d   = tx_byte;
               tx_active_d = 1'b1;
               tx_state_d  = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q < BIT_LAST) tx_cnt_d = tx_cnt_q + CW'(1);
            else begin
               tx_cnt_d   = '0;
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_cnt_q < BIT_LAST) begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end else begin
               tx_cnt_d = '0;
               if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
               else                  tx_idx_d   = tx_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (tx_cnt_q < BIT_LAST) begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end else begin
               tx_cnt_d    = '0;
               tx_done_d   = 1'b1;
               tx_active_d = 1'b0;
               tx_state_d  = S_CLEANUP;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      // The line level is registered from the next state so it changes glitch-free.
      case (tx_state_d)
         S_START: tx_serial_d = 1'b0;
         S_DATA:  tx_serial_d = tx_data_d[tx_idx_d];
         default: tx_serial_d = 1'b1;
      endcase
   end

   assign o_rx_dv     = rx_dv_q;
   assign o_rx_byte   = rx_byte_q;
   assign o_tx_uart   = tx_serial_q;
   assign o_tx_active = tx_active_q;
   assign o_tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: frames are built and decoded from the 8N1 rules directly.
module tb_uart_txrx;
   localparam int CPB = 217;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_line;
   logic       o_rx_dv;
   logic [7:0] o_rx_byte;
   logic       i_tx_dv;
   logic [7:0] i_tx_byte;
   logic       o_tx_uart;
   logic       o_tx_active;
   logic       o_tx_done;

   int n_checks = 0;
   int n_fail   = 0;
   int rx_dv_cnt = 0;
   int tx_done_cnt = 0;
   logic [7:0] got_q[$];

   uart_txrx #(.clks_per_bit(CPB)) dut (
      .i_clock(clk), .i_rst_n(rst_n), .i_rx_uart(rx_line),
      .o_rx_dv(o_rx_dv), .o_rx_byte(o_rx_byte),
      .i_tx_dv(i_tx_dv), .i_tx_byte(i_tx_byte),
      .o_tx_uart(o_tx_uart), .o_tx_active(o_tx_active), .o_tx_done(o_tx_done)
   );

   always #20 clk = ~clk;

   always @(negedge clk) begin
      if (o_rx_dv) begin
         rx_dv_cnt++;
         got_q.push_back(o_rx_byte);
      end
      if (o_tx_done) tx_done_cnt++;
   end

   // Line levels of a frame, index 0 = start bit, 9 = stop bit.
   function automatic logic [9:0] frame_of(input logic [7:0] b, input logic stop);
      return {stop, b, 1'b0};
   endfunction

   // Called at a negedge; drives one full frame onto the receive line.
   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = frame_of(b, stop);
      for (int k = 0; k < 10; k++) begin
         rx_line = fr[k];
         repeat (CPB) @(negedge clk);
      end
      rx_line = 1'b1;
   endtask

   // Called at the negedge just after acceptance; samples each bit near both ends.
   task automatic capture_tx(output logic [9:0] early, output logic [9:0] late,
                             output logic act_all, input bit inject);
      act_all = 1'b1;
      early = '0;
      late  = '0;
      for (int c = 0; c < 10 * CPB; c++) begin
         if (c % CPB == 1)       early[c / CPB] = o_tx_uart;
         if (c % CPB == CPB - 2) late[c / CPB]  = o_tx_uart;
         if (o_tx_active !== 1'b1) act_all = 1'b0;
         if (inject && c == 4 * CPB + 7) begin i_tx_dv = 1'b1; i_tx_byte = 8'($urandom); end
         if (inject && c == 4 * CPB + 8) i_tx_dv = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_tx(input logic [7:0] b, input bit inject);
      logic [9:0] early, late, exp;
      logic act;
      int d0;
      d0 = tx_done_cnt;
      exp = frame_of(b, 1'b1);
      i_tx_dv = 1'b1;
      i_tx_byte = b;
      @(negedge clk);
      i_tx_dv = 1'b0;
      i_tx_byte = 8'($urandom);
      n_checks++;
      if (o_tx_uart !== 1'b0) begin
         n_fail++; $display("FAIL tx_start_latency byte=%h line=%b required 0", b, o_tx_uart);
      end
      capture_tx(early, late, act, inject);
      n_checks++;
      if (early !== exp || late !== exp) begin
         n_fail++; $display("FAIL tx_frame byte=%h early=%b late=%b required %b", b, early, late, exp);
      end
      n_checks++;
      if (act !== 1'b1) begin
         n_fail++; $display("FAIL tx_active_during_frame byte=%h got %b required 1", b, act);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx_done_cnt - d0 !== 1 || o_tx_active !== 1'b0 || o_tx_uart !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_done byte=%h pulses=%0d active=%b line=%b required 1,0,1",
                  b, tx_done_cnt - d0, o_tx_active, o_tx_uart);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rx_line = 1'b1;
      i_tx_dv = 1'b0;
      i_tx_byte = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({o_rx_dv, o_rx_byte, o_tx_uart, o_tx_active, o_tx_done} !== 12'b0_00000000_100) begin
         n_fail++;
         $display("FAIL reset_state rx_dv=%b rx_byte=%h tx=%b act=%b done=%b required 0,00,1,0,0",
                  o_rx_dv, o_rx_byte, o_tx_uart, o_tx_active, o_tx_done);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_rx_single;
      int c, d0;
      d0 = rx_dv_cnt;
      c = 0;
      fork
         send_rx(8'h14, 1'b1);
         begin
            while (!o_rx_dv && c < 3000) begin @(negedge clk); c++; end
         end
      join
      n_checks++;
      if (c < 2055 || c > 2075) begin
         n_fail++; $display("FAIL rx_latency cycles=%0d required 2055..2075", c);
      end
      repeat (250) @(negedge clk);
      n_checks++;
      if (rx_dv_cnt - d0 !== 1 || o_rx_byte !== 8'h14) begin
         n_fail++; $display("FAIL rx_single pulses=%0d byte=%h required 1,14", rx_dv_cnt - d0, o_rx_byte);
      end
   endtask

   task automatic test_back_to_back;
      got_q.delete();
      send_rx(8'h00, 1'b1);
      send_rx(8'hFF, 1'b1);
      repeat (5) @(negedge clk);
      n_checks++;
      if (got_q.size() !== 2 || got_q[0] !== 8'h00 || got_q[1] !== 8'hFF) begin
         n_fail++;
         $display("FAIL rx_back_to_back count=%0d first=%h second=%h required 2,00,ff",
                  got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx, got_q.size() > 1 ? got_q[1] : 8'hxx);
      end
   endtask

   task automatic test_glitch_and_framing;
      int d0;
      d0 = rx_dv_cnt;
      rx_line = 1'b0;
      repeat (50) @(negedge clk);
      rx_line = 1'b1;
      repeat (300) @(negedge clk);
      n_checks++;
      if (rx_dv_cnt !== d0) begin
         n_fail++; $display("FAIL rx_glitch pulses=%0d required 0", rx_dv_cnt - d0);
      end
      send_rx(8'h3C, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      n_checks++;
      if (rx_dv_cnt !== d0 || o_rx_byte !== 8'hFF) begin
         n_fail++;
         $display("FAIL rx_framing_error pulses=%0d byte=%h required 0,ff", rx_dv_cnt - d0, o_rx_byte);
      end
      send_rx(8'hA5, 1'b1);
      repeat (5) @(negedge clk);
      n_checks++;
      if (rx_dv_cnt - d0 !== 1 || o_rx_byte !== 8'hA5) begin
         n_fail++; $display("FAIL rx_after_glitch pulses=%0d byte=%h required 1,a5", rx_dv_cnt - d0, o_rx_byte);
      end
   endtask

   task automatic test_full_duplex(input int iters);
      logic [7:0] rb, tb;
      for (int i = 0; i < iters; i++) begin
         rb = 8'($urandom);
         tb = 8'($urandom);
         got_q.delete();
         fork
            send_rx(rb, 1'b1);
            test_tx(tb, i == 0);
         join
         repeat (5) @(negedge clk);
         n_checks++;
         if (got_q.size() !== 1 || got_q[0] !== rb) begin
            n_fail++;
            $display("FAIL duplex_rx iter=%0d count=%0d byte=%h required 1,%h",
                     i, got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx, rb);
         end
      end
   endtask

   task automatic test_reset_midframe;
      int d_rx, d_tx;
      d_rx = rx_dv_cnt;
      d_tx = tx_done_cnt;
      i_tx_dv = 1'b1;
      i_tx_byte = 8'($urandom);
      rx_line = 1'b0;
      @(negedge clk);
      i_tx_dv = 1'b0;
      repeat (5 * CPB + CPB / 2) @(negedge clk);
      #7 rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_tx_uart !== 1'b1 || o_tx_active !== 1'b0 || o_rx_dv !== 1'b0 || o_tx_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort tx=%b act=%b rx_dv=%b done=%b required 1,0,0,0",
                  o_tx_uart, o_tx_active, o_rx_dv, o_tx_done);
      end
      rx_line = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      n_checks++;
      if (rx_dv_cnt !== d_rx || tx_done_cnt !== d_tx) begin
         n_fail++;
         $display("FAIL reset_no_pulses rx_dv=%0d tx_done=%0d required 0,0", rx_dv_cnt - d_rx, tx_done_cnt - d_tx);
      end
      test_full_duplex(1);
   endtask

   task automatic test_echo;
      logic [9:0] early, late, exp;
      logic act;
      int c, k, d0;
      d0 = tx_done_cnt;
      exp = frame_of(8'h14, 1'b1);
      c = 0;
      k = 0;
      fork
         send_rx(8'h14, 1'b1);
         begin
            while (!o_rx_dv && c < 3000) begin @(negedge clk); c++; end
            while (o_tx_uart && k < 3) begin @(negedge clk); k++; end
            n_checks++;
            if (k > 2 || c >= 3000) begin
               n_fail++; $display("FAIL echo_start wait=%0d rx_wait=%0d required <=2", k, c);
            end
            capture_tx(early, late, act, 1'b0);
            n_checks++;
            if (early !== exp || late !== exp || act !== 1'b1) begin
               n_fail++; $display("FAIL echo_frame early=%b late=%b act=%b required %b,1", early, late, act, exp);
            end
         end
      join
      repeat (5) @(negedge clk);
      n_checks++;
      if (tx_done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL echo_done pulses=%0d required 1", tx_done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_rx_single();
      test_back_to_back();
      test_glitch_and_framing();
`ifdef UART_ECHO_EN
      test_echo();
`else
      test_tx(8'h44, 1'b0);
      test_full_duplex(3);
      test_reset_midframe();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
